// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART transmit and receive paths.
// Frame: 1 start, NUM_DATA_BITS data LSB first, 1 even-parity bit, 1 stop bit.
package uart_pkg;

   localparam int NUM_DATA_BITS = 8;
   localparam int STOP_BITS     = 1;
   localparam bit PARITY_EVEN   = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO, one-cycle write-to-read visibility, registered level counter.
// Push is dropped while full and pop is ignored while empty; full does not look ahead at a same-cycle pop.
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: byte FIFO feeding an 11-bit frame serialiser; frames start on a baud tick once data and cts are present.
// tx_ready is combinational ~full; cts is only sampled at frame start, back-to-back frames have no idle bit.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = NUM_DATA_BITS,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          baud_tick,
   input  logic [DATA_BITS-1:0]          tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   input  logic                          cts,
   output logic                          txd,
   output logic                          busy,
   output logic                          done,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

   tx_state_t            state, state_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic [CW-1:0]        bit_cnt, bit_cnt_n;
   logic                 par, par_n;
   logic                 txd_n, busy_n, done_n;

   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 fifo_pop;
   logic [DATA_BITS-1:0] fifo_dout;

   assign tx_ready = ~fifo_full;

   uart_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (tx_valid),
      .din   (tx_data),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         par     <= 1'b0;
         txd     <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         shreg   <= shreg_n;
         bit_cnt <= bit_cnt_n;
         par     <= par_n;
         txd     <= txd_n;
         busy    <= busy_n;
         done    <= done_n;
      end
   end

   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      bit_cnt_n = bit_cnt;
      par_n     = par;
      txd_n     = txd;
      busy_n    = busy;
      done_n    = 1'b0;
      fifo_pop  = 1'b0;

      if (baud_tick) begin
         case (state)
            IDLE: begin
               txd_n  = 1'b1;
               busy_n = 1'b0;
               if (!fifo_empty && cts) begin
                  fifo_pop = 1'b1;
                  shreg_n  = fifo_dout;
                  par_n    = ^fifo_dout;
                  txd_n    = 1'b0;
                  busy_n   = 1'b1;
                  state_n  = START;
               end
            end
            START: begin
               txd_n     = shreg[0];
               shreg_n   = shreg >> 1;
               bit_cnt_n = '0;
               state_n   = DATA;
            end
            DATA: begin
               // bit_cnt indexes the data bit currently on the line
               if (bit_cnt == LAST_BIT) begin
                  txd_n   = par;
                  state_n = PARITY;
               end else begin
                  txd_n     = shreg[0];
                  shreg_n   = shreg >> 1;
                  bit_cnt_n = bit_cnt + 1'b1;
               end
            end
            PARITY: begin
               txd_n   = 1'b1;
               state_n = STOP;
            end
            STOP: begin
               done_n = 1'b1;
               if (!fifo_empty && cts) begin
                  fifo_pop = 1'b1;
                  shreg_n  = fifo_dout;
                  par_n    = ^fifo_dout;
                  txd_n    = 1'b0;
                  busy_n   = 1'b1;
                  state_n  = START;
               end else begin
                  txd_n   = 1'b1;
                  busy_n  = 1'b0;
                  state_n = IDLE;
               end
            end
            default: begin
               txd_n   = 1'b1;
               busy_n  = 1'b0;
               state_n = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed + randomized bench for uart_tx_ctrl; the line is sampled once per bit period
// and compared against 11-bit frames built from the byte stream the bench pushed.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       baud_tick;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       cts;
   logic       txd;
   logic       busy;
   logic       done;
   logic [2:0] level;

   int errors = 0;
   int checks = 0;

   bit   line_q[$];
   int   done_cnt;
   int   busy_clks;
   logic tick_q;
   int   tcnt;

   uart_tx_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .baud_tick (baud_tick),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .cts       (cts),
      .txd       (txd),
      .busy      (busy),
      .done      (done),
      .level     (level)
   );

   always #10 clk = ~clk;

   // Baud tick every 16 clocks, driven away from the sampling edge.
   initial begin
      baud_tick = 1'b0;
      tcnt      = 0;
      forever begin
         @(negedge clk);
         tcnt      = (tcnt + 1) % 16;
         baud_tick = (tcnt == 0);
      end
   end

   always @(posedge clk) tick_q <= baud_tick;

   always @(negedge clk) begin
      if (tick_q) line_q.push_back(txd);
      if (done) done_cnt++;
      if (busy) busy_clks++;
   end

   function automatic logic [10:0] frame_bits(input logic [7:0] b);
      logic [10:0] f;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = b[i];
      f[9]  = ($countones(b) % 2) != 0;
      f[10] = 1'b1;
      return f;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic clear_mon();
      line_q.delete();
      done_cnt  = 0;
      busy_clks = 0;
   endtask

   task automatic push_byte(input logic [7:0] b);
      @(negedge clk);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_busy(input string tag);
      int w = 0;
      while (!busy && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk(tag, busy, 1);
   endtask

   // Decode line samples into frames; contiguous demands no idle bit between frames.
   task automatic check_line(input string tag, input logic [7:0] exp_q[$], input bit contiguous);
      int          idx = 0;
      logic [10:0] obs;
      bit          tail_ok = 1'b1;
      for (int f = 0; f < exp_q.size(); f++) begin
         if (!contiguous || f == 0) begin
            while (idx < line_q.size() && line_q[idx] == 1'b1) idx++;
         end
         for (int k = 0; k < 11; k++) begin
            obs[k] = (idx < line_q.size()) ? logic'(line_q[idx]) : 1'bx;
            idx++;
         end
         chk($sformatf("%s_frame%0d", tag, f), obs, frame_bits(exp_q[f]));
      end
      for (int i = idx; i < line_q.size(); i++) begin
         if (line_q[i] != 1'b1) tail_ok = 1'b0;
      end
      chk({tag, "_idle_after"}, tail_ok, 1);
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] b;

      reset    = 1'b1;
      tx_valid = 1'b0;
      tx_data  = '0;
      cts      = 1'b1;
      clear_mon();
      wait_clks(3);
      chk("rst_txd", txd, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_level", level, 0);
      chk("rst_ready", tx_ready, 1);
      reset = 1'b0;
      wait_clks(40);

      // Single frame 0xA5: parity 0
      clear_mon();
      push_byte(8'hA5);
      wait_clks(11 * 16 + 60);
      q = '{8'hA5};
      check_line("a5", q, 1'b1);
      chk("a5_done", done_cnt, 1);
      chk("a5_busy_clks", busy_clks, 11 * 16);

      // Single frame 0x07: parity 1
      clear_mon();
      push_byte(8'h07);
      wait_clks(11 * 16 + 60);
      q = '{8'h07};
      check_line("x07", q, 1'b1);
      chk("x07_busy_clks", busy_clks, 11 * 16);
      chk("x07_done", done_cnt, 1);

      // Back-to-back 0x55, 0xFF
      clear_mon();
      push_byte(8'h55);
      push_byte(8'hFF);
      wait_clks(22 * 16 + 60);
      q = '{8'h55, 8'hFF};
      check_line("b2b", q, 1'b1);
      chk("b2b_done", done_cnt, 2);
      chk("b2b_busy_clks", busy_clks, 22 * 16);

      // Flow control: cts low, 5 random pushes, only 4 accepted
      clear_mon();
      cts = 1'b0;
      q.delete();
      for (int i = 0; i < 4; i++) begin
         b = 8'($urandom);
         q.push_back(b);
         push_byte(b);
      end
      chk("fc_ready_full", tx_ready, 0);
      chk("fc_level_full", level, 4);
      push_byte(8'($urandom));
      chk("fc_level_after5", level, 4);
      wait_clks(200);
      chk("fc_no_tx_done", done_cnt, 0);
      begin
         logic [7:0] none_q[$];
         check_line("fc_hold", none_q, 1'b1);
      end
      cts = 1'b1;
      wait_clks(4 * 11 * 16 + 80);
      check_line("fc_send", q, 1'b1);
      chk("fc_done", done_cnt, 4);
      chk("fc_level_empty", level, 0);
      chk("fc_ready_after", tx_ready, 1);

      // cts drops in DATA of frame 1 with 2 bytes queued
      clear_mon();
      q.delete();
      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom);
         q.push_back(b);
         push_byte(b);
      end
      wait_busy("cts_start");
      wait_clks(48);
      cts = 1'b0;
      wait_clks(11 * 16 + 100);
      chk("cts_done_hold", done_cnt, 1);
      chk("cts_level_hold", level, 2);
      chk("cts_busy_hold", busy, 0);
      cts = 1'b1;
      wait_clks(2 * 11 * 16 + 80);
      check_line("cts", q, 1'b0);
      chk("cts_done_all", done_cnt, 3);

      // Reset during DATA with 3 bytes queued
      clear_mon();
      for (int i = 0; i < 4; i++) push_byte(8'($urandom));
      wait_busy("rstm_start");
      wait_clks(48);
      chk("rstm_level_before", level, 3);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rstm_txd", txd, 1);
      chk("rstm_busy", busy, 0);
      chk("rstm_level", level, 0);
      chk("rstm_ready", tx_ready, 1);
      @(negedge clk);
      reset = 1'b0;
      clear_mon();
      wait_clks(3 * 11 * 16);
      chk("rstm_done_after", done_cnt, 0);
      begin
         logic [7:0] none_q[$];
         check_line("rstm_quiet", none_q, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit stage that consumes bytes from the monitor's control/switch logic and serialises them onto `uart_txd`. It sits downstream of the `tx_byte` source in the monitor top level and is the transmit-side counterpart to the existing receiver. It uses the same frame format: 1 start bit, 8 data bits LSB first, 1 even-parity bit and 1 stop bit, 11 bits per frame. A small FIFO decouples byte producers from line rate, and CTS gates the start of each frame.

## Interface
Parameters:
- `DATA_BITS`, 8, data bits per frame; taken from the shared data-bit constant.
- `FIFO_DEPTH`, 4, byte FIFO entries; must be a power of 2 and ≥ 2.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  reset; one clock, synchronous, active-high.
- `baud_tick`  in  1  one-`clk`-wide pulse per bit time at `BAUD_RATE_TX`.
- `tx_data`  in  `DATA_BITS`  byte to enqueue.
- `tx_valid`  in  1  enqueue request.
- `tx_ready`  out  1  FIFO not full; a push occurs when `tx_valid && tx_ready` is high on a `clk` edge.
- `cts`  in  1  clear to send, active-high; the top level inverts it if the pin is active-low.
- `txd`  out  1  serial line, idles high.
- `busy`  out  1  frame in progress (START through STOP).
- `done`  out  1  one-`clk` pulse at the end of each stop bit.
- `level`  out  `$clog2(FIFO_DEPTH)+1`  FIFO occupancy.

## Operation
- Reset values: `txd`=1, `busy`=0, `done`=0, `level`=0. `tx_ready`=1, because it is combinational `~full`. State is IDLE and the FIFO is empty.
- The FSM has five states: IDLE, START, DATA, PARITY and STOP. All state advances happen only on `clk` edges where `baud_tick`=1.
- IDLE → START:
  - Condition: `baud_tick` && FIFO not empty && `cts`=1.
  - The FIFO head is popped into the shift register in the same cycle.
  - Parity is latched as `^data`, which gives even parity: the total count of ones in data plus parity is even.
- START → DATA after one tick.
- DATA shifts LSB first. The bit counter counts 0..`DATA_BITS`-1, and the FSM moves to PARITY on the tick after the last bit.
- PARITY → STOP after one tick.
- STOP → leaving:
  - On the tick that ends STOP, `done` pulses.
  - If the FIFO is non-empty and `cts`=1, the FSM goes directly to START, popping the next byte. There is no idle bit between frames.
  - Otherwise it goes to IDLE.
- `cts` is sampled only at frame start. Deasserting it mid-frame never aborts or stretches the current frame.
- FIFO full:
  - `tx_ready`=0 and pushes are ignored.
  - A push and a pop in the same cycle while full is not accepted, because ready does not look ahead.
- FIFO empty with a pop requested: impossible, since the IDLE/STOP conditions already check for a non-empty FIFO.
- Simultaneous push and pop when not full or empty: `level` is unchanged.
- FIFO pointers wrap modulo `FIFO_DEPTH`. `level` saturates naturally in the range 0..`FIFO_DEPTH`.
- Reset mid-frame: on the next edge `txd`=1, the FSM is IDLE, the FIFO is flushed and the partial frame is dropped.

## Timing
- `txd`, `busy` and `done` are registered and change on the `clk` edge where `baud_tick`=1.
- Each bit lasts exactly one tick period.
- Push-to-start latency:
  - A byte pushed at edge t is visible at t+1.
  - START begins at the first tick edge ≥ t+1 where `cts`=1.
- Frame length is 11 tick periods. `busy` is high from the START edge to the edge that ends STOP.
- `done` is high for exactly one `clk` cycle, coincident with the STOP → IDLE/START edge.
- `level` updates on the push/pop edge.

## Structure
- Shared package `uart_pkg` (alongside `uart_globals.svh` constants) holds:
  - `NUM_DATA_BITS`
  - the `tx_state_t` enum {IDLE, START, DATA, PARITY, STOP}
  - the `STOP_BITS`/`PARITY_EVEN` constants shared with the receiver.
- Sub-module `uart_fifo`:
  - A parameterised synchronous FIFO with push/pop/full/empty/level.
  - It is reusable later for the receive path.
- The FSM, shift register, bit counter and parity register live in `uart_tx_ctrl`.

## Test plan
- Single frame, 0xA5 pushed, `cts`=1, tick every 16 clks:
  - Required `txd` = 0, 1,0,1,0,0,1,0,1, 0, 1. Parity is 0 because 0xA5 has four ones.
  - Each bit is held 16 clks and `done` pulses once.
- Single frame, 0x07:
  - Required parity bit = 1.
  - `busy` is high for exactly 11×16 clks.
- Back-to-back, push 0x55 then 0xFF:
  - 22 consecutive bit periods with no high idle bit between the two frames.
  - `done` pulses twice.
  - Parity bits are 0 and 0.
- Flow control: `cts`=0, push 5 bytes:
  - `tx_ready` drops after the 4th push, `level`=4, the 5th byte is dropped and `txd` stays 1.
  - Raise `cts` → 4 frames are sent, in order.
- `cts` drops during DATA of frame 1 with 2 bytes queued:
  - Frame 1 completes all 11 bits.
  - Frame 2 starts only after `cts` returns to 1.
- Reset asserted during DATA with 3 bytes queued:
  - Next edge: `txd`=1, `busy`=0, `level`=0, `tx_ready`=1.
  - No further frames are sent after release.
